mux_scan_ctrl: RTL and testbench

Sequencer that sits directly upstream of the 4x1 mux tree (three mux_2x1 instances). It drives the mux select lines and samples the mux output.
- On a start request it walks sel through every channel, holding each for a programmable settle (dwell) time.
- It captures the mux output on the last dwell cycle of each channel.
- It presents the assembled channel snapshot to a consumer over a valid/ready handshake.

---
 rtl/mux_scan_pkg.sv | 14 +
 rtl/mux_scan_ctrl_dwell_timer.sv | 39 +++
 rtl/mux_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer: state encoding and widths.
// Imported by mux_scan_ctrl and dwell_timer.
package mux_scan_pkg;

  localparam int DWELL_W   = 4;
  localparam int N_SEL_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// Loadable dwell counter with clear, enable and a terminal-count flag.
// The count wraps to zero on the enabled cycle where it reaches term.
module dwell_timer
  import mux_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               en,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic [DWELL_W-1:0] term,
  output logic               tc
);

  logic [DWELL_W-1:0] count_r;

  // dwell count register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {DWELL_W{1'b0}};
    end else if (clr) begin
      count_r <= {DWELL_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (en) begin
      if (tc) begin
        count_r <= {DWELL_W{1'b0}};
      end else begin
        count_r <= count_r + DWELL_W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == term);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the mux tree: steps sel through every channel, samples
// mux_y on the last dwell cycle of each, and hands the snapshot over valid/ready.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int N_SEL = N_SEL_DEF,
  parameter int DWELL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mux_y,
  output logic [N_SEL-1:0]      sel,
  output logic                  busy,
  output logic [(2**N_SEL)-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready
);

  localparam int                 CH       = 2**N_SEL;
  localparam logic [DWELL_W-1:0] TERM     = DWELL_W'(DWELL - 1);
  localparam logic [N_SEL-1:0]   SEL_LAST = N_SEL'(CH - 1);

  state_t          state_r, state_nxt;
  logic [N_SEL-1:0] sel_r, sel_nxt;
  logic            busy_r, busy_nxt;
  logic            valid_r, valid_nxt;
  logic [CH-1:0]   data_r, data_nxt;
  logic [CH-1:0]   shadow_r, shadow_nxt;
  logic            tc_s;

  // Counter is held clear outside SETTLE, so every channel starts from zero.
  dwell_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_r != ST_SETTLE),
    .en       (state_r == ST_SETTLE),
    .load     (1'b0),
    .load_val ({DWELL_W{1'b0}}),
    .term     (TERM),
    .tc       (tc_s)
  );

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      sel_r    <= {N_SEL{1'b0}};
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      data_r   <= {CH{1'b0}};
      shadow_r <= {CH{1'b0}};
    end else begin
      state_r  <= state_nxt;
      sel_r    <= sel_nxt;
      busy_r   <= busy_nxt;
      valid_r  <= valid_nxt;
      data_r   <= data_nxt;
      shadow_r <= shadow_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt = ST_SETTLE;
        else       state_nxt = ST_IDLE;
      end
      ST_SETTLE: begin
        if (tc_s && (sel_r == SEL_LAST)) state_nxt = ST_HOLD;
        else                             state_nxt = ST_SETTLE;
      end
      ST_HOLD: begin
        if (data_ready) state_nxt = start ? ST_SETTLE : ST_IDLE;
        else            state_nxt = ST_HOLD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // next values of the registered outputs and the shadow snapshot
  always_comb begin
    sel_nxt    = sel_r;
    busy_nxt   = busy_r;
    valid_nxt  = valid_r;
    data_nxt   = data_r;
    shadow_nxt = shadow_r;
    case (state_r)
      ST_IDLE: begin
        sel_nxt   = {N_SEL{1'b0}};
        valid_nxt = 1'b0;
        if (start) begin
          busy_nxt   = 1'b1;
          shadow_nxt = {CH{1'b0}};
        end else begin
          busy_nxt = 1'b0;
        end
      end
      ST_SETTLE: begin
        busy_nxt = 1'b1;
        if (tc_s) begin
          shadow_nxt[sel_r] = mux_y;
          if (sel_r == SEL_LAST) begin
            data_nxt  = shadow_nxt;
            valid_nxt = 1'b1;
          end else begin
            sel_nxt = sel_r + N_SEL'(1);
          end
        end else begin
          sel_nxt = sel_r;
        end
      end
      ST_HOLD: begin
        if (data_ready) begin
          valid_nxt = 1'b0;
          sel_nxt   = {N_SEL{1'b0}};
          if (start) begin
            busy_nxt   = 1'b1;
            shadow_nxt = {CH{1'b0}};
          end else begin
            busy_nxt = 1'b0;
          end
        end else begin
          valid_nxt = 1'b1;
        end
      end
      default: begin
        sel_nxt   = {N_SEL{1'b0}};
        busy_nxt  = 1'b0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  assign sel        = sel_r;
  assign busy       = busy_r;
  assign data       = data_r;
  assign data_valid = valid_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (DWELL 2, 1, 3) each driving a
// behavioural 4x1 mux, with a scoreboard checking every presented snapshot.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start_v, ready_v, busy_v, valid_v;
  logic [3:0] i_v    [3];
  logic [1:0] sel_v  [3];
  logic [3:0] data_v [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         inst;
    logic [3:0] data;
    int         due;
  } exp_t;
  exp_t sb_q[$];
  logic [2:0] prev_valid = 3'b000;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DW = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    logic my;
    assign my = i_v[g][sel_v[g]];
    mux_scan_ctrl #(.N_SEL(2), .DWELL(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start_v[g]),
      .mux_y      (my),
      .sel        (sel_v[g]),
      .busy       (busy_v[g]),
      .data       (data_v[g]),
      .data_valid (valid_v[g]),
      .data_ready (ready_v[g])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dw(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d act=%0h exp=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // scoreboard monitor: each rising data_valid must match the oldest expectation
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (valid_v[k] === 1'b1 && prev_valid[k] === 1'b0) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected inst=%0d act=valid exp=none", k);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_inst", k, k, e.inst);
          chk("sb_data", k, data_v[k], e.data);
          chk("sb_latency", k, cyc, e.due);
        end
      end
    end
    prev_valid <= valid_v;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // called #1 after an edge with instance k idle; returns the accept edge
  task automatic start_scan(input int k, output int ea);
    chk("idle_busy", k, busy_v[k], 0);
    start_v[k] = 1'b1;
    ready_v[k] = 1'($urandom);
    i_v[k]     = 4'($urandom);
    step();
    ea = cyc;
  endtask

  task automatic check_zero(input int k);
    chk("rst_sel", k, sel_v[k], 0);
    chk("rst_busy", k, busy_v[k], 0);
    chk("rst_valid", k, valid_v[k], 0);
    chk("rst_data", k, data_v[k], 0);
  endtask

  // drive one scan from its accept edge through the handshake edge
  task automatic scan_body(input int k, input int ea, input logic [3:0] tgt,
                           input int hold_wait, input bit next_start, output int hs);
    int d;
    d = dw(k);
    sb_q.push_back('{inst: k, data: tgt, due: ea + 4 * d});
    for (int m = 0; m < 4 * d; m++) begin
      logic [3:0] iv;
      int ch;
      ch = m / d;
      iv = 4'($urandom);
      // only the last dwell cycle of a channel carries the true value
      if (m == (ch + 1) * d - 1) iv[ch] = tgt[ch];
      else                       iv[ch] = ~tgt[ch];
      i_v[k]     = iv;
      start_v[k] = 1'($urandom);
      ready_v[k] = 1'($urandom);
      chk("settle_sel", k, sel_v[k], ch);
      chk("settle_busy", k, busy_v[k], 1);
      step();
    end
    for (int w = 0; w < hold_wait; w++) begin
      ready_v[k] = 1'b0;
      start_v[k] = 1'($urandom);
      i_v[k]     = 4'($urandom);
      chk("hold_valid", k, valid_v[k], 1);
      chk("hold_data", k, data_v[k], tgt);
      chk("hold_sel", k, sel_v[k], 3);
      step();
    end
    chk("hs_valid_before", k, valid_v[k], 1);
    ready_v[k] = 1'b1;
    start_v[k] = next_start;
    i_v[k]     = 4'($urandom);
    step();
    hs = cyc;
    ready_v[k] = 1'b0;
    start_v[k] = 1'b0;
    chk("hs_valid_after", k, valid_v[k], 0);
    chk("hs_busy_after", k, busy_v[k], next_start);
    chk("hs_sel_after", k, sel_v[k], 0);
    chk("hs_data_kept", k, data_v[k], tgt);
  endtask

  initial begin
    int ea;
    int d;
    bit nb;
    rst_n   = 1'b0;
    start_v = 3'b000;
    ready_v = 3'b000;
    for (int k = 0; k < 3; k++) i_v[k] = 4'b0000;
    step();
    step();
    for (int k = 0; k < 3; k++) check_zero(k);
    rst_n = 1'b1;
    step();

    start_scan(0, ea);
    scan_body(0, ea, 4'b1010, 0, 1'b0, ea);
    step();
    start_scan(0, ea);
    scan_body(0, ea, 4'b0110, 5, 1'b1, ea);
    scan_body(0, ea, 4'b0001, 0, 1'b0, ea);

    // reset while sel==2, then a clean scan
    start_scan(0, ea);
    d = dw(0);
    for (int m = 0; m < 2 * d; m++) begin
      i_v[0] = 4'($urandom);
      step();
    end
    chk("mid_sel", 0, sel_v[0], 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) check_zero(k);
    start_scan(0, ea);
    scan_body(0, ea, 4'b1001, 1, 1'b0, ea);

    start_scan(1, ea);
    scan_body(1, ea, 4'b1100, 0, 1'b0, ea);
    start_scan(2, ea);
    scan_body(2, ea, 4'b0010, 2, 1'b0, ea);

    for (int k = 0; k < 3; k++) begin
      repeat (3) begin
        start_scan(k, ea);
        nb = 1'($urandom);
        scan_body(k, ea, 4'($urandom), $urandom_range(0, 3), nb, ea);
        while (nb) begin
          nb = ($urandom_range(0, 2) == 0);
          scan_body(k, ea, 4'($urandom), $urandom_range(0, 3), nb, ea);
        end
        repeat ($urandom_range(0, 2)) step();
      end
    end

    repeat (4) step();
    chk("sb_empty", 0, sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
